axi4_lite_cmd_master: RTL and testbench

Parametrised AXI4-Lite master driven by a valid/ready command port. It replaces level-triggered START pulses with explicit request handshakes. It adds WSTRB, concurrent AW/W issue, response-code reporting and a watchdog timeout. Read and write engines are fully independent and sit between fabric-side logic and any axi4_lite slave.

---
 rtl/axi4_lite_pkg.sv | 31 +++
 rtl/axi4_lite_watchdog.sv | 41 ++++
 rtl/axi4_lite_cmd_master.sv | 257 +++++++++++++++++++++++++
 tb/tb_axi4_lite_cmd_master.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite command master.
//   resp_t       : AXI response codes as carried on BRESP/RRESP
//   w_state_t    : write engine states
//   r_state_t    : read engine states
//   data_width_ok: elaboration-time legality test for DATA_WIDTH
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE      = 2'd0,
    W_ADDR_DATA = 2'd1,
    W_RESP      = 2'd2
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } r_state_t;

  function automatic bit data_width_ok(input int unsigned w);
    return (w == 32) || (w == 64);
  endfunction

endpackage

// File: rtl/axi4_lite_watchdog.sv
// Per-direction transaction watchdog.
//   clk_i, rst_ni : clock, async active-low reset
//   start_i       : command accepted this cycle (clears the count)
//   busy_i        : engine is outside its idle state
//   expired_o     : one-cycle strobe on the cycle the count reaches LIMIT
// The count saturates at LIMIT, so the strobe fires once per transaction and a
// sticky flag fed from it can be cleared even while the transaction is stuck.
// LIMIT = 0 removes the counter entirely.
module axi4_lite_watchdog #(
  parameter int unsigned LIMIT = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic busy_i,
  output logic expired_o
);

  if (LIMIT == 0) begin : g_off
    logic unused_in;
    assign unused_in = ^{clk_i, rst_ni, start_i, busy_i};
    assign expired_o = 1'b0;
  end else begin : g_on
    localparam int CW = $clog2(LIMIT + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (start_i)                             cnt_d = '0;
      else if (busy_i && cnt_q != CW'(LIMIT))  cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
    end

    assign expired_o = busy_i && (cnt_q == CW'(LIMIT - 1));
  end

endmodule

// File: rtl/axi4_lite_cmd_master.sv
// AXI4-Lite master with independent valid/ready write and read command ports.
//   ACLK/ARESETN            : clock, async active-low reset
//   wr_req_*, wr_addr/data/strb -> AW+W issue, B collect -> wr_done/wr_resp
//   rd_req_*, rd_addr           -> AR issue, R collect   -> rd_done/rd_data/rd_resp
//   timeout_err {rd,wr}     : sticky watchdog flags, cleared by timeout_clr
//   AW/W/B/AR/R             : AXI4-Lite master channels, all outputs registered
// Error responses are only reported; they never change the engine flow, and a
// watchdog expiry never aborts a transaction (VALID must stay up per AXI).
module axi4_lite_cmd_master
  import axi4_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter logic [2:0]  PROT_VAL       = 3'b000,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  localparam int unsigned STRB_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  wr_req_valid,
  output logic                  wr_req_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [STRB_WIDTH-1:0] wr_strb,
  output logic                  wr_done,
  output logic [1:0]            wr_resp,
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_done,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [1:0]            rd_resp,
  output logic [1:0]            timeout_err,
  input  logic                  timeout_clr,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic [2:0]            AWPROT,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic [STRB_WIDTH-1:0] WSTRB,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [2:0]            ARPROT,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RVALID,
  output logic                  RREADY
);

  if (!data_width_ok(DATA_WIDTH)) begin : g_bad_width
    $error("axi4_lite_cmd_master: DATA_WIDTH must be 32 or 64");
  end

  // ---------------- write engine ----------------
  w_state_t              wstate_q, wstate_d;
  logic                  wr_rdy_q, wr_rdy_d, awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic                  bready_q, bready_d, aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                  wr_done_q, wr_done_d;
  logic [1:0]            wr_resp_q, wr_resp_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  wr_acc;

  // Ready is a flop that mirrors "next state is idle", so it is low in reset
  // and high again on the same cycle as wr_done.
  assign wr_acc = wr_req_valid && wr_rdy_q;

  always_comb begin
    wstate_d  = wstate_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    wr_done_d = 1'b0;
    wr_resp_d = wr_resp_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    case (wstate_q)
      W_IDLE: if (wr_acc) begin
        awaddr_d  = wr_addr;
        wdata_d   = wr_data;
        wstrb_d   = wr_strb;
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        wstate_d  = W_ADDR_DATA;
      end
      W_ADDR_DATA: begin
        // AW and W retire independently, in either order or together.
        aw_done_d = aw_done_q | (awvalid_q & AWREADY);
        w_done_d  = w_done_q  | (wvalid_q  & WREADY);
        awvalid_d = awvalid_q & ~AWREADY;
        wvalid_d  = wvalid_q  & ~WREADY;
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          wstate_d = W_RESP;
        end
      end
      W_RESP: if (BVALID) begin
        bready_d  = 1'b0;
        wr_resp_d = BRESP;
        wr_done_d = 1'b1;
        wstate_d  = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
    wr_rdy_d = (wstate_d == W_IDLE);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wstate_q  <= W_IDLE;
      wr_rdy_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      wr_done_q <= 1'b0;
      wr_resp_q <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      wstate_q  <= wstate_d;
      wr_rdy_q  <= wr_rdy_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      wr_done_q <= wr_done_d;
      wr_resp_q <= wr_resp_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  // ---------------- read engine ----------------
  r_state_t              rstate_q, rstate_d;
  logic                  rd_rdy_q, rd_rdy_d, arvalid_q, arvalid_d, rready_q, rready_d;
  logic                  rd_done_q, rd_done_d;
  logic [1:0]            rd_resp_q, rd_resp_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_acc;

  assign rd_acc = rd_req_valid && rd_rdy_q;

  always_comb begin
    rstate_d  = rstate_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    rd_done_d = 1'b0;
    rd_resp_d = rd_resp_q;
    rd_data_d = rd_data_q;
    araddr_d  = araddr_q;
    case (rstate_q)
      R_IDLE: if (rd_acc) begin
        araddr_d  = rd_addr;
        arvalid_d = 1'b1;
        rstate_d  = R_ADDR;
      end
      R_ADDR: if (ARREADY) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
        rstate_d  = R_DATA;
      end
      R_DATA: if (RVALID) begin
        rready_d  = 1'b0;
        rd_data_d = RDATA;
        rd_resp_d = RRESP;
        rd_done_d = 1'b1;
        rstate_d  = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
    rd_rdy_d = (rstate_d == R_IDLE);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rstate_q  <= R_IDLE;
      rd_rdy_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      rd_done_q <= 1'b0;
      rd_resp_q <= '0;
      rd_data_q <= '0;
      araddr_q  <= '0;
    end else begin
      rstate_q  <= rstate_d;
      rd_rdy_q  <= rd_rdy_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      rd_done_q <= rd_done_d;
      rd_resp_q <= rd_resp_d;
      rd_data_q <= rd_data_d;
      araddr_q  <= araddr_d;
    end
  end

  // ---------------- watchdogs ----------------
  logic       wr_exp, rd_exp;
  logic [1:0] to_err_q, to_err_d;

  axi4_lite_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wd_wr (
    .clk_i(ACLK), .rst_ni(ARESETN), .start_i(wr_acc),
    .busy_i(wstate_q != W_IDLE), .expired_o(wr_exp)
  );

  axi4_lite_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wd_rd (
    .clk_i(ACLK), .rst_ni(ARESETN), .start_i(rd_acc),
    .busy_i(rstate_q != R_IDLE), .expired_o(rd_exp)
  );

  // A new expiry on the clear cycle survives the clear.
  assign to_err_d = (to_err_q & ~{2{timeout_clr}}) | {rd_exp, wr_exp};

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) to_err_q <= '0;
    else          to_err_q <= to_err_d;
  end

  // ---------------- outputs ----------------
  assign wr_req_ready = wr_rdy_q;
  assign wr_done      = wr_done_q;
  assign wr_resp      = wr_resp_q;
  assign rd_req_ready = rd_rdy_q;
  assign rd_done      = rd_done_q;
  assign rd_data      = rd_data_q;
  assign rd_resp      = rd_resp_q;
  assign timeout_err  = to_err_q;
  assign AWADDR       = awaddr_q;
  assign AWPROT       = PROT_VAL;
  assign AWVALID      = awvalid_q;
  assign WDATA        = wdata_q;
  assign WSTRB        = wstrb_q;
  assign WVALID       = wvalid_q;
  assign BREADY       = bready_q;
  assign ARADDR       = araddr_q;
  assign ARPROT       = PROT_VAL;
  assign ARVALID      = arvalid_q;
  assign RREADY       = rready_q;

endmodule

// File: tb/tb_axi4_lite_cmd_master.sv
// Directed + randomized bench for axi4_lite_cmd_master (32-bit, TIMEOUT_CYCLES=8).
// A delay-programmable slave answers the AXI channels; expected results come
// from the command/response values the bench chose and from the handshake
// timing rules (done = accept + 2 + address-phase delay + response delay).
module tb_axi4_lite_cmd_master;
  import axi4_lite_pkg::*;

  logic        ACLK, ARESETN;
  logic        wr_req_valid, wr_req_ready, wr_done;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;
  logic [1:0]  wr_resp;
  logic        rd_req_valid, rd_req_ready, rd_done;
  logic [31:0] rd_addr, rd_data;
  logic [1:0]  rd_resp, timeout_err;
  logic        timeout_clr;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [2:0]  AWPROT, ARPROT;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0]  BRESP, RRESP;

  axi4_lite_cmd_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .PROT_VAL(3'b000), .TIMEOUT_CYCLES(8)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_done(wr_done), .wr_resp(wr_resp),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_addr(rd_addr),
    .rd_done(rd_done), .rd_data(rd_data), .rd_resp(rd_resp),
    .timeout_err(timeout_err), .timeout_clr(timeout_clr),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int errors = 0, checks = 0, proto_bad = 0, wr_done_cnt = 0, rd_done_cnt = 0;
  int s_awd, s_wd, s_bd, s_ard, s_rd;
  logic [1:0]  s_br, s_rr;
  logic [31:0] s_rdata, exp_awaddr, exp_wdata, exp_araddr, last_rd;
  logic [3:0]  exp_wstrb;
  bit          aw_got, w_got;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave: READY after N cycles of VALID, response N cycles after the address
  // phase(s). Response payload is scrambled whenever it is not valid.
  initial begin : slave
    int awc, wc, arc, bc, rc;
    bit ar_got, bclr, rclr;
    AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
    BRESP = 0; RDATA = 0; RRESP = 0;
    awc = 0; wc = 0; arc = 0; bc = 0; rc = 0; ar_got = 0; aw_got = 0; w_got = 0;
    forever begin
      @(posedge ACLK);
      bclr = 0; rclr = 0;
      if (ARESETN) begin
        if (AWVALID && AWREADY) aw_got = 1;
        if (WVALID && WREADY)   w_got  = 1;
        if (ARVALID && ARREADY) ar_got = 1;
        if (BVALID && BREADY)   bclr   = 1;
        if (RVALID && RREADY)   rclr   = 1;
      end
      #1;
      if (!ARESETN) begin
        AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
        awc = 0; wc = 0; arc = 0; bc = 0; rc = 0; ar_got = 0; aw_got = 0; w_got = 0;
      end else begin
        if (bclr) begin BVALID = 0; aw_got = 0; w_got = 0; bc = 0; end
        else if (aw_got && w_got && !BVALID) begin
          if (bc >= s_bd) begin BVALID = 1; BRESP = s_br; end else bc++;
        end
        if (!BVALID) BRESP = 2'($urandom);
        if (rclr) begin RVALID = 0; ar_got = 0; rc = 0; end
        else if (ar_got && !RVALID) begin
          if (rc >= s_rd) begin RVALID = 1; RDATA = s_rdata; RRESP = s_rr; end else rc++;
        end
        if (!RVALID) begin RDATA = $urandom; RRESP = 2'($urandom); end
        if (AWVALID) begin AWREADY = (awc >= s_awd); awc++; end else begin AWREADY = 0; awc = 0; end
        if (WVALID)  begin WREADY  = (wc  >= s_wd);  wc++;  end else begin WREADY  = 0; wc  = 0; end
        if (ARVALID) begin ARREADY = (arc >= s_ard); arc++; end else begin ARREADY = 0; arc = 0; end
      end
    end
  end

  // Protocol monitor: payload stability under VALID, BREADY gating, PROT.
  always @(negedge ACLK) begin
    if (ARESETN) begin
      if (AWVALID && AWADDR !== exp_awaddr) proto_bad++;
      if (WVALID && (WDATA !== exp_wdata || WSTRB !== exp_wstrb)) proto_bad++;
      if (ARVALID && ARADDR !== exp_araddr) proto_bad++;
      if (BREADY && !(aw_got && w_got)) proto_bad++;
      if (AWPROT !== 3'b000 || ARPROT !== 3'b000) proto_bad++;
      if (wr_done) wr_done_cnt++;
      if (rd_done) rd_done_cnt++;
    end
  end

  task automatic run_txn(input bit dw, input bit dr,
      input logic [31:0] wa, input logic [31:0] wdat, input logic [3:0] ws,
      input int awd, input int wdl, input int bd, input logic [1:0] br,
      input logic [31:0] ra, input logic [31:0] rdat, input int ard, input int rdl,
      input logic [1:0] rr, input bit chk_to);
    int wl, rl, wmax;
    logic [1:0]  wresp_got, rresp_got;
    logic [31:0] rdata_got;
    wl = 0; rl = 0; wmax = (awd > wdl) ? awd : wdl;
    wresp_got = '0; rresp_got = '0; rdata_got = '0;
    @(negedge ACLK);
    s_awd = awd; s_wd = wdl; s_bd = bd; s_br = br;
    s_ard = ard; s_rd = rdl; s_rdata = rdat; s_rr = rr;
    if (dw) begin
      chk("wr_req_ready", wr_req_ready, 1);
      exp_awaddr = wa; exp_wdata = wdat; exp_wstrb = ws;
      wr_req_valid = 1; wr_addr = wa; wr_data = wdat; wr_strb = ws;
    end
    if (dr) begin
      chk("rd_req_ready", rd_req_ready, 1);
      exp_araddr = ra;
      rd_req_valid = 1; rd_addr = ra;
    end
    @(posedge ACLK); #1;
    wr_req_valid = 0; rd_req_valid = 0;
    wr_addr = $urandom; wr_data = $urandom; wr_strb = 4'($urandom); rd_addr = $urandom;
    for (int k = 1; k <= 80; k++) begin
      @(posedge ACLK); #1;
      if (dw && wl == 0) begin
        chk("awvalid", AWVALID, k <= awd);
        chk("wvalid", WVALID, k <= wdl);
        chk("bready", BREADY, (k >= wmax + 1) && (k < wmax + 2 + bd));
        if (wr_done) begin
          wl = k; wresp_got = wr_resp;
          chk("wr_ready_on_done", wr_req_ready, 1);
        end
      end else if (dw && k == wl + 1) chk("wr_done_pulse", wr_done, 0);
      if (dr && rl == 0) begin
        chk("arvalid", ARVALID, k <= ard);
        chk("rready", RREADY, (k >= ard + 1) && (k < ard + 2 + rdl));
        if (rd_done) begin
          rl = k; rdata_got = rd_data; rresp_got = rd_resp;
          chk("rd_ready_on_done", rd_req_ready, 1);
        end
      end else if (dr && k == rl + 1) chk("rd_done_pulse", rd_done, 0);
      if (chk_to && k == 7) chk("timeout_before_limit", timeout_err, 2'b00);
      if (chk_to && k == 8) chk("timeout_at_limit", timeout_err, 2'b10);
      if ((!dw || (wl != 0 && k > wl)) && (!dr || (rl != 0 && k > rl))) break;
    end
    if (dw) begin
      chk("wr_done_seen", wl != 0, 1);
      chk("wr_latency", wl, 2 + wmax + bd);
      chk("wr_resp", wresp_got, br);
    end
    if (dr) begin
      chk("rd_done_seen", rl != 0, 1);
      chk("rd_latency", rl, 2 + ard + rdl);
      chk("rd_data", rdata_got, rdat);
      chk("rd_resp", rresp_got, rr);
      last_rd = rdat;
    end
    chk("rd_data_hold", rd_data, last_rd);
    chk("protocol", proto_bad, 0);
  endtask

  initial begin
    int n;
    bit r_dw, r_dr;
    int sel;
    ARESETN = 0; timeout_clr = 0; last_rd = '0;
    wr_req_valid = 0; wr_addr = 0; wr_data = 0; wr_strb = 0;
    rd_req_valid = 0; rd_addr = 0;
    s_awd = 0; s_wd = 0; s_bd = 0; s_ard = 0; s_rd = 0; s_br = 0; s_rr = 0; s_rdata = 0;
    exp_awaddr = 0; exp_wdata = 0; exp_wstrb = 0; exp_araddr = 0;
    #12;
    chk("reset_ctl", {AWVALID, WVALID, BREADY, ARVALID, RREADY, wr_done, rd_done,
                      wr_req_ready, rd_req_ready, wr_resp, rd_resp, timeout_err}, 15'h0);
    chk("reset_data", {rd_data, AWADDR}, 64'h0);
    @(negedge ACLK); ARESETN = 1;
    repeat (2) @(negedge ACLK);
    chk("ready_after_reset", {wr_req_ready, rd_req_ready}, 2'b11);

    // Write, all READY immediate.
    run_txn(1, 0, 32'h10, 32'hDEAD_BEEF, 4'b0011, 0, 0, 0, OKAY, 0, 0, 0, 0, OKAY, 0);
    // AWREADY late by 4, WREADY immediate.
    run_txn(1, 0, 32'h10, 32'h0BAD_CAFE, 4'hF, 4, 0, 0, OKAY, 0, 0, 0, 0, OKAY, 0);
    // Read with late RVALID and SLVERR.
    run_txn(0, 1, 0, 0, 0, 0, 0, 0, OKAY, 32'h20, 32'h1234_5678, 0, 3, SLVERR, 0);
    // Concurrent, interleaved slave timing.
    run_txn(1, 1, 32'h100, 32'hA5A5_0F0F, 4'hC, 1, 2, 1, DECERR,
            32'h200, 32'h5A5A_F0F0, 2, 0, EXOKAY, 0);

    for (int i = 0; i < 8; i++) begin
      sel = int'($urandom_range(0, 2));
      r_dw = (sel != 1); r_dr = (sel != 0);
      run_txn(r_dw, r_dr, $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom),
              int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
              2'($urandom), $urandom & 32'hFFFF_FFFC, $urandom,
              int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 2'($urandom), 0);
    end
    chk("no_timeout_short_txns", timeout_err, 2'b00);

    // Watchdog: ARREADY withheld 20 cycles against a limit of 8.
    run_txn(0, 1, 0, 0, 0, 0, 0, 0, OKAY, 32'h30, 32'hCAFE_F00D, 20, 0, OKAY, 1);
    chk("timeout_sticky", timeout_err, 2'b10);
    @(negedge ACLK); timeout_clr = 1;
    @(negedge ACLK); timeout_clr = 0;
    chk("timeout_cleared", timeout_err, 2'b00);

    // Reset while waiting in the response phase.
    @(negedge ACLK);
    s_awd = 0; s_wd = 0; s_bd = 10;
    exp_awaddr = 32'h40; exp_wdata = 32'h0BAD_F00D; exp_wstrb = 4'hF;
    wr_req_valid = 1; wr_addr = 32'h40; wr_data = 32'h0BAD_F00D; wr_strb = 4'hF;
    @(posedge ACLK); #1 wr_req_valid = 0;
    repeat (3) @(posedge ACLK);
    #2;
    chk("rst_bready_before", BREADY, 1);
    n = wr_done_cnt;
    ARESETN = 0; #1;
    chk("rst_async_drop", {AWVALID, WVALID, BREADY, wr_req_ready}, 4'b0);
    repeat (2) @(negedge ACLK);
    ARESETN = 1;
    repeat (2) @(negedge ACLK);
    chk("rst_ready_after", {wr_req_ready, rd_req_ready}, 2'b11);
    chk("rst_no_done", wr_done_cnt, n);
    chk("protocol_final", proto_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
